// File: rtl/imgpix_unpack.sv
// imgpix_unpack: pops BUSW-bit words from the image FIFO and serialises them
// MSB-first into BPP-bit pixels, one per display pixel request. Tracks the
// horizontal position so the unused tail of a line's final word is dropped
// and every line starts on a word boundary. It never stalls the display.
// When it has no pixel to give, it flags an underflow instead.
//
// Optional feature macro: IMGPIX_UFCOUNT_EN adds o_ufcount. This is a 16-bit
// saturating count of underflow events. i_reset and i_newframe clear it.
module imgpix_unpack #(
    parameter int BUSW = 32,
    parameter int BPP  = 8,
    parameter int LW   = 11
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_newframe,
    input  logic [LW-1:0]   i_hpixels,
    input  logic            i_valid,
    input  logic [BUSW-1:0] i_word,
    output logic            o_rd,
    input  logic            i_pix_rdy,
    output logic [BPP-1:0]  o_pixel,
    output logic            o_pix_valid,
    output logic            o_eol,
    output logic            o_underflow
`ifdef IMGPIX_UFCOUNT_EN
    ,
    output logic [15:0]     o_ufcount
`endif
);

    localparam int PPW = BUSW / BPP;
    localparam int NW  = $clog2(PPW + 1);

    logic [BUSW-1:0] r_sreg;
    logic [NW-1:0]   r_npix;
    logic [LW-1:0]   r_hpos;
    logic            r_eol;
    logic            r_underflow;

    logic            w_flush;
    logic            w_empty;
    logic            w_last;
    logic            w_consume;
    logic            w_under;
    logic            w_rd;

    // Pixel-slot bookkeeping. An i_hpixels value of 0 wraps to all ones,
    // which gives the 2**LW line length with no special case.
    always_comb begin
        w_flush   = i_reset || i_newframe;
        w_empty   = (r_npix == '0);
        w_last    = (r_hpos == (i_hpixels - LW'(1)));
        w_consume = i_pix_rdy && !w_empty;
        w_under   = i_pix_rdy && w_empty;
        w_rd      = !w_flush && i_valid &&
                    (w_empty || (i_pix_rdy && ((r_npix == NW'(1)) || w_last)));
    end

    // Shift register, pixel count, horizontal position and event pulses.
    // A word load takes priority over the consume shift. This lets the next
    // word arrive in the same cycle its predecessor drains, with no bubble.
    always_ff @(posedge i_clk) begin
        if (w_flush) begin
            r_sreg      <= '0;
            r_npix      <= '0;
            r_hpos      <= '0;
            r_eol       <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_eol       <= i_pix_rdy && w_last;
            r_underflow <= w_under;
            if (i_pix_rdy) begin
                r_hpos <= w_last ? '0 : r_hpos + LW'(1);
            end
            if (w_rd) begin
                r_sreg <= i_word;
                r_npix <= NW'(PPW);
            end else if (w_consume) begin
                r_sreg <= r_sreg << BPP;
                r_npix <= w_last ? '0 : r_npix - NW'(1);
            end
        end
    end

`ifdef IMGPIX_UFCOUNT_EN
    logic [15:0] r_ufcount;

    // Saturating underflow event counter.
    always_ff @(posedge i_clk) begin
        if (w_flush) begin
            r_ufcount <= '0;
        end else if (w_under && (r_ufcount != 16'hffff)) begin
            r_ufcount <= r_ufcount + 16'd1;
        end
    end

    assign o_ufcount = r_ufcount;
`endif

    assign o_rd        = w_rd;
    assign o_pixel     = r_sreg[BUSW-1 -: BPP];
    assign o_pix_valid = !w_empty;
    assign o_eol       = r_eol;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_imgpix_unpack.sv
// Scoreboard bench for imgpix_unpack (BUSW=32, BPP=8, LW=11).
// Stimulus pushes hand-computed expected pixels into exp_q. A negedge monitor
// pops exp_q and compares whenever a pixel is consumed.
module tb_imgpix_unpack;

    logic        clk = 1'b0;
    logic        i_reset, i_newframe, i_valid, i_pix_rdy;
    logic [10:0] i_hpixels;
    logic [31:0] i_word;
    logic        o_rd, o_pix_valid, o_eol, o_underflow;
    logic [7:0]  o_pixel;
`ifdef IMGPIX_UFCOUNT_EN
    logic [15:0] o_ufcount;
`endif

    imgpix_unpack #(.BUSW(32), .BPP(8), .LW(11)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_newframe  (i_newframe),
        .i_hpixels   (i_hpixels),
        .i_valid     (i_valid),
        .i_word      (i_word),
        .o_rd        (o_rd),
        .i_pix_rdy   (i_pix_rdy),
        .o_pixel     (o_pixel),
        .o_pix_valid (o_pix_valid),
        .o_eol       (o_eol),
        .o_underflow (o_underflow)
`ifdef IMGPIX_UFCOUNT_EN
        ,
        .o_ufcount   (o_ufcount)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] fifo_q[$];
    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          pops = 0, eols = 0, ufs = 0;
    logic        rd_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic refresh();
        i_valid = (fifo_q.size() != 0);
        i_word  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    task automatic exp_pix(input logic [7:0] p);
        exp_q.push_back(p);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: sample mid-cycle, score consumed pixels and count events.
    always @(negedge clk) begin
        rd_seen = o_rd;
        if (o_rd) pops++;
        if (o_eol) eols++;
        if (o_underflow) ufs++;
        if (!i_reset && !i_newframe && i_pix_rdy && o_pix_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pixel", {24'h0, o_pixel}, 32'hxxxxxxxx);
            end else begin
                chk("pixel", {24'h0, o_pixel}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // FIFO model: pop the head word after an edge where o_rd was high.
    always @(posedge clk) begin
        #1;
        if (rd_seen) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            rd_seen = 1'b0;
        end
        refresh();
    end

    int p0, e0, u0;

    task automatic mark();
        p0 = pops; e0 = eols; u0 = ufs;
    endtask

    initial begin
        i_reset = 1'b1; i_newframe = 1'b0; i_pix_rdy = 1'b0; i_hpixels = 11'd8;
        refresh();
        // T6a: reset held while a word is waiting must not pop.
        push_word(32'hDEADBEEF);
        i_pix_rdy = 1'b1;
        cyc(2);
        @(negedge clk);
        chk("rst_no_rd", {31'h0, o_rd}, 32'h0);
        chk("rst_pix_valid", {31'h0, o_pix_valid}, 32'h0);
        chk("rst_pixel", {24'h0, o_pixel}, 32'h0);
        chk("rst_eol", {31'h0, o_eol}, 32'h0);
        chk("rst_uf", {31'h0, o_underflow}, 32'h0);
        fifo_q.delete(); refresh();
        i_pix_rdy = 1'b0;
        cyc(1);
        i_reset = 1'b0;
        cyc(1);

        // T1: two words, 8-pixel line, continuous requests.
        mark();
        push_word(32'h01020304); push_word(32'h05060708);
        for (int i = 1; i <= 8; i++) exp_pix(8'(i));
        cyc(1);
        i_pix_rdy = 1'b1; cyc(8);
        i_pix_rdy = 1'b0; cyc(2);
        chk("t1_pops", pops - p0, 2);
        chk("t1_eol", eols - e0, 1);
        chk("t1_uf", ufs - u0, 0);

        // T2: 6-pixel line, tail of second word discarded.
        mark();
        i_hpixels = 11'd6;
        push_word(32'hAABBCCDD); push_word(32'h11223344); push_word(32'h55667788);
        exp_pix(8'hAA); exp_pix(8'hBB); exp_pix(8'hCC); exp_pix(8'hDD);
        exp_pix(8'h11); exp_pix(8'h22);
        exp_pix(8'h55); exp_pix(8'h66); exp_pix(8'h77); exp_pix(8'h88);
        cyc(1);
        i_pix_rdy = 1'b1; cyc(10);
        i_pix_rdy = 1'b0; cyc(2);
        chk("t2_pops", pops - p0, 3);
        chk("t2_eol", eols - e0, 1);
        chk("t2_uf", ufs - u0, 0);

        // T3: empty FIFO, three requests on a 3-pixel line.
        i_newframe = 1'b1; i_hpixels = 11'd3; cyc(1);
        i_newframe = 1'b0;
        mark();
        i_pix_rdy = 1'b1; cyc(3);
        i_pix_rdy = 1'b0;
        @(negedge clk);
        chk("t3_pix_valid", {31'h0, o_pix_valid}, 32'h0);
        cyc(2);
        chk("t3_uf", ufs - u0, 3);
        chk("t3_eol", eols - e0, 1);
        chk("t3_pops", pops - p0, 0);
`ifdef IMGPIX_UFCOUNT_EN
        chk("t3_ufcount", {16'h0, o_ufcount}, 32'd3);
`endif

        // T4: newframe with two pixels left while a pop would otherwise occur.
        mark();
        push_word(32'h10203040);
        exp_pix(8'h10); exp_pix(8'h20);
        cyc(1);
        i_pix_rdy = 1'b1; cyc(2);
        i_newframe = 1'b1;
        push_word(32'hA1B2C3D4);
        @(negedge clk);
        chk("t4_nf_no_rd", {31'h0, o_rd}, 32'h0);
        cyc(1);
        i_newframe = 1'b0; i_pix_rdy = 1'b0;
        @(negedge clk);
        chk("t4_nf_flushed", {31'h0, o_pix_valid}, 32'h0);
        chk("t4_nf_rd", {31'h0, o_rd}, 32'h1);
        cyc(1);
        exp_pix(8'hA1); exp_pix(8'hB2); exp_pix(8'hC3);
        i_pix_rdy = 1'b1; cyc(3);
        i_pix_rdy = 1'b0; cyc(2);
        chk("t4_pops", pops - p0, 2);
        chk("t4_eol", eols - e0, 1);
        chk("t4_uf", ufs - u0, 0);
`ifdef IMGPIX_UFCOUNT_EN
        chk("t4_ufcount_clr", {16'h0, o_ufcount}, 32'd0);
`endif

        // T5: toggling requests with the FIFO always primed.
        mark();
        i_hpixels = 11'd8;
        push_word(32'h11121314); push_word(32'h21222324);
        push_word(32'h31323334); push_word(32'h41424344);
        for (int w = 1; w <= 4; w++)
            for (int b = 1; b <= 4; b++) exp_pix(8'((w << 4) | b));
        cyc(1);
        for (int i = 0; i < 32; i++) begin
            i_pix_rdy = (i % 2 == 0);
            cyc(1);
        end
        i_pix_rdy = 1'b0; cyc(2);
        chk("t5_pops", pops - p0, 4);
        chk("t5_eol", eols - e0, 2);
        chk("t5_uf", ufs - u0, 0);

        // T6b: reset mid-word while a pop condition is true.
        i_hpixels = 11'd2;
        push_word(32'h99AABBCC);
        exp_pix(8'h99);
        cyc(1);
        i_pix_rdy = 1'b1; cyc(1);
        i_reset = 1'b1;
        push_word(32'h01234567);
        @(negedge clk);
        chk("t6_rst_no_rd", {31'h0, o_rd}, 32'h0);
        cyc(1);
        fifo_q.delete(); refresh();
        i_reset = 1'b0; i_pix_rdy = 1'b0;
        @(negedge clk);
        chk("t6_pix_valid", {31'h0, o_pix_valid}, 32'h0);
        chk("t6_pixel", {24'h0, o_pixel}, 32'h0);
        chk("t6_eol", {31'h0, o_eol}, 32'h0);
        chk("t6_uf", {31'h0, o_underflow}, 32'h0);
        cyc(2);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
